shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 71 +++++++
 tb/tb_shift_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle barrel shifter applying 16/8/4/2/1 stages over five clock edges
module shift_sequencer (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_data_in,
  input  logic [4:0]  i_shamt,
  input  logic [1:0]  i_op,
  output logic [31:0] o_out,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [4:0]  r_shamt;
  logic [1:0]  r_op;
  logic [4:0]  w_dist;
  logic        w_en;
  logic [31:0] w_stage;
  // One fixed-distance stage of 2^cnt bits; reserved op leaves the operand untouched
  always_comb begin
    w_dist  = 5'd1 << r_cnt;
    w_en    = r_shamt[r_cnt] && (r_op != 2'b11);
    w_stage = !w_en ? o_out :
              (r_op == 2'b00) ? o_out << w_dist :
              (r_op == 2'b01) ? o_out >> w_dist :
              32'($signed(o_out) >>> w_dist);
  end
  // Sequencer: capture on accept, shift one stage per edge, pulse done, return to idle
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_shamt <= 5'd0;
      r_op    <= 2'b00;
      o_out   <= 32'h0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_state <= SHIFT;
          r_cnt   <= 3'd4;
          r_shamt <= i_shamt;
          r_op    <= i_op;
          o_out   <= i_data_in;
          o_busy  <= 1'b1;
          o_err   <= (i_op == 2'b11);
        end
        SHIFT: begin
          o_out <= w_stage;
          if (r_cnt == 3'd0) begin
            r_state <= DONE;
            o_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed vectors with a done-triggered scoreboard monitor
module tb_shift_sequencer;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic [31:0] out;
  logic        busy, done, err;
  int          n_vec = 0;
  int          n_err = 0;
  logic [32:0] exp_q[$];

  shift_sequencer dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_data_in(data_in),
    .i_shamt(shamt), .i_op(op), .o_out(out), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got out %h with no pending expectation", out);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({err, out} !== e) begin
          n_err++;
          $display("FAIL result: got err=%b out=%h expected err=%b out=%h", err, out, e[32], e[31:0]);
        end
      end
    end
  end

  // Called at a negedge; start is accepted at the following edge t0, returns after t6
  task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o,
                       input logic [31:0] want, input bit junk);
    logic e_err;
    e_err = (o == 2'b11);
    start = 1'b1; data_in = d; shamt = s; op = o;
    exp_q.push_back({e_err, want});
    @(negedge clk);
    start = 1'b0;
    check("busy_after_t0", 32'(busy), 32'd1);
    check("err_after_t0", 32'(err), 32'(e_err));
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = junk && (i == 1);
      if (start) begin data_in = 32'hFFFFFFFF; shamt = 5'd1; op = 2'b00; end
      else begin data_in = 32'h5A5A5A5A; shamt = 5'd31; op = 2'b10; end
    end
    check("done_low_before_t5", 32'(done), 32'd0);
    @(negedge clk);
    check("done_after_t5", 32'(done), 32'd1);
    check("busy_after_t5", 32'(busy), 32'd1);
    @(negedge clk);
    check("done_after_t6", 32'(done), 32'd0);
    check("busy_after_t6", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_in = 32'h0; shamt = 5'd0; op = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_out", out, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    issue(32'h0000ABCD, 5'd16, 2'b00, 32'hABCD0000, 1'b0);
    issue(32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF, 1'b0);
    issue(32'h80000000, 5'd31, 2'b01, 32'h00000001, 1'b0);
    issue(32'h12345678, 5'd0,  2'b00, 32'h12345678, 1'b0);
    issue(32'hFFFF0000, 5'd13, 2'b01, 32'h0007FFF8, 1'b0);
    issue(32'h00000003, 5'd30, 2'b00, 32'hC0000000, 1'b0);
    issue(32'hF0000000, 5'd4,  2'b01, 32'h0F000000, 1'b1);
    // Abort mid-shift: reset at t3 must leave no done pulse behind
    start = 1'b1; data_in = 32'h00000001; shamt = 5'd31; op = 2'b00;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out", out, 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    issue(32'h00000001, 5'd1, 2'b00, 32'h00000002, 1'b0);
    // Start coinciding with reset is ignored
    rst = 1'b1; start = 1'b1; data_in = 32'h11111111; shamt = 5'd3; op = 2'b00;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("start_with_reset_busy", 32'(busy), 32'd0);
    check("start_with_reset_out", out, 32'h0);
    issue(32'hDEADBEEF, 5'd7, 2'b11, 32'hDEADBEEF, 1'b0);
    check("err_held_in_idle", 32'(err), 32'd1);
    issue(32'h80000000, 5'd4, 2'b10, 32'hF8000000, 1'b0);
    check("out_held_in_idle", out, 32'hF8000000);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
